sargantana_icache_refill_ctrl: RTL

- Line-fill initiator for one icache way.
- Accepts a miss for a line address and issues one line request to the memory side.
- Collects the response beats into a full set-width line, then issues a single write (req/we/addr/data) into the way SRAM at the line's index.
- Supports a kill (flush) that aborts the fill and drains outstanding beats without writing the way.

---
 rtl/sargantana_icache_refill_ctrl.sv | 124 ++++++++++++
 1 files changed

// File: rtl/sargantana_icache_refill_ctrl.sv
// Line-fill controller for one icache way: issues one memory line request, assembles the
// response beats into a full line, and writes it into the way SRAM. A kill drains the beats.
module sargantana_icache_refill_ctrl #(
    parameter int unsigned ICACHE_DEPTH    = 64,
    parameter int unsigned SET_WIDHT       = 256,
    parameter int unsigned ADDR_WIDHT      = 6,
    parameter int unsigned BEAT_WIDHT      = 64,
    parameter int unsigned LINE_ADDR_WIDHT = 26
) (
    input  logic                       clk_i,
    input  logic                       rstn_i,
    input  logic                       miss_valid_i,
    output logic                       miss_ready_o,
    input  logic [LINE_ADDR_WIDHT-1:0] miss_line_addr_i,
    input  logic                       kill_i,
    output logic                       mem_req_valid_o,
    input  logic                       mem_req_ready_i,
    output logic [LINE_ADDR_WIDHT-1:0] mem_req_addr_o,
    input  logic                       mem_rsp_valid_i,
    input  logic [BEAT_WIDHT-1:0]      mem_rsp_data_i,
    output logic                       way_req_o,
    output logic                       way_we_o,
    output logic [ADDR_WIDHT-1:0]      way_addr_o,
    output logic [SET_WIDHT-1:0]       way_data_o,
    output logic                       fill_done_o
);

    localparam int unsigned BEATS     = SET_WIDHT / BEAT_WIDHT;
    localparam int unsigned CNT_WIDHT = $clog2(BEATS);

    if (ADDR_WIDHT != $clog2(ICACHE_DEPTH) || BEATS < 2 || (BEATS & (BEATS - 1)) != 0 ||
        LINE_ADDR_WIDHT < ADDR_WIDHT) begin : g_param_check
        $error("sargantana_icache_refill_ctrl: inconsistent parameters");
    end

    typedef enum logic [2:0] {StIdle, StReq, StFill, StWrite, StDrain} state_e;

    state_e                     state_q, state_d;
    logic [LINE_ADDR_WIDHT-1:0] addr_q, addr_d;
    logic [CNT_WIDHT-1:0]       cnt_q, cnt_d;
    logic [SET_WIDHT-1:0]       line_q, line_d;
    logic                       last_beat;

    assign last_beat      = (cnt_q == CNT_WIDHT'(BEATS - 1));
    assign mem_req_addr_o = addr_q;
    assign way_addr_o     = addr_q[ADDR_WIDHT-1:0];
    assign way_data_o     = line_q;

    always_comb begin
        state_d         = state_q;
        addr_d          = addr_q;
        cnt_d           = cnt_q;
        line_d          = line_q;
        miss_ready_o    = 1'b0;
        mem_req_valid_o = 1'b0;
        way_req_o       = 1'b0;
        way_we_o        = 1'b0;
        fill_done_o     = 1'b0;

        unique case (state_q)
            StIdle: begin
                miss_ready_o = ~kill_i;
                if (miss_valid_i && !kill_i) begin
                    addr_d  = miss_line_addr_i;
                    cnt_d   = '0;
                    state_d = StReq;
                end
            end
            StReq: begin
                mem_req_valid_o = 1'b1;
                if (mem_req_ready_i) begin
                    cnt_d   = '0;
                    state_d = kill_i ? StDrain : StFill;
                end else if (kill_i) begin
                    state_d = StIdle;
                end
            end
            StFill: begin
                if (mem_rsp_valid_i) begin
                    line_d[cnt_q*BEAT_WIDHT +: BEAT_WIDHT] = mem_rsp_data_i;
                    cnt_d = cnt_q + CNT_WIDHT'(1);
                    if (last_beat) begin
                        state_d = kill_i ? StIdle : StWrite;
                    end else if (kill_i) begin
                        state_d = StDrain;
                    end
                end else if (kill_i) begin
                    state_d = StDrain;
                end
            end
            StWrite: begin
                way_req_o   = 1'b1;
                way_we_o    = 1'b1;
                fill_done_o = 1'b1;
                state_d     = StIdle;
            end
            StDrain: begin
                // Beats that are still in flight are counted but never land in the line buffer
                if (mem_rsp_valid_i) begin
                    cnt_d = cnt_q + CNT_WIDHT'(1);
                    if (last_beat) begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= StIdle;
            addr_q  <= '0;
            cnt_q   <= '0;
            line_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            line_q  <= line_d;
        end
    end

endmodule
